// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and default widths for the register-file write-port arbiter.
// The default data and register-address widths live here.
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int REG_ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_AUX
  } grant_t;

  // A registered stall hands the port to the aux head regardless of pipe_we.
  function automatic grant_t pick_grant(
    input logic stall,
    input logic pipe_we,
    input logic nonempty
  );
    if (!stall && pipe_we) begin
      return GNT_PIPE;
    end else if (nonempty) begin
      return GNT_AUX;
    end else begin
      return GNT_NONE;
    end
  endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_aux_fifo: in-order buffer of aux write-back results.
// WBARB_FWD_EN exports the entry array and write pointer for forwarding.
module wb_aux_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = REG_ADDR_W_DEF,
  parameter int DEPTH  = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count,
  output logic [ADDR_W-1:0] o_head_addr,
`ifdef WBARB_FWD_EN
  output logic [DATA_W-1:0]       o_head_data,
  output logic [DEPTH*ADDR_W-1:0] o_ent_addr,
  output logic [DEPTH*DATA_W-1:0] o_ent_data,
  output logic [PW-1:0]           o_wptr
`else
  output logic [DATA_W-1:0] o_head_data
`endif
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_head_addr = r_addr[r_rptr];
  assign o_head_data = r_data[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= i_addr;
      r_data[r_wptr] <= i_data;
    end
  end

`ifdef WBARB_FWD_EN
  assign o_wptr = r_wptr;
  for (genvar g = 0; g < DEPTH; g++) begin : g_exp
    assign o_ent_addr[g*ADDR_W +: ADDR_W] = r_addr[g];
    assign o_ent_data[g*DATA_W +: DATA_W] = r_data[g];
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs buffered aux results.
// WBARB_FWD_EN adds a forwarding lookup over the aux buffer and rf_* stage.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = REG_ADDR_W_DEF,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int PW          = $clog2(FIFO_DEPTH),
  localparam int CW          = PW + 1,
  localparam int WCW         = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic [CW-1:0]     aux_pending,
`ifdef WBARB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_push;
  logic              w_pop;
  grant_t            w_grant;

  logic              r_stall;
  logic [WCW-1:0]    r_wait;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

`ifdef WBARB_FWD_EN
  logic [FIFO_DEPTH*ADDR_W-1:0] w_ent_addr;
  logic [FIFO_DEPTH*DATA_W-1:0] w_ent_data;
  logic [PW-1:0]                w_wptr;
  logic [PW-1:0]                w_idx;
`endif

  assign aux_ready   = !w_full;
  assign aux_pending = w_count;
  assign pipe_stall  = r_stall;
  assign rf_we       = r_we;
  assign rf_waddr    = r_waddr;
  assign rf_wdata    = r_wdata;

  assign w_push  = aux_valid && aux_ready;
  assign w_grant = pick_grant(r_stall, pipe_we, !w_empty);
  assign w_pop   = (w_grant == GNT_AUX);

  wb_aux_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_addr      (aux_addr),
    .i_data      (aux_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_head_addr (w_head_addr),
`ifdef WBARB_FWD_EN
    .o_head_data (w_head_data),
    .o_ent_addr  (w_ent_addr),
    .o_ent_data  (w_ent_data),
    .o_wptr      (w_wptr)
`else
    .o_head_data (w_head_data)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      unique case (w_grant)
        GNT_PIPE: begin
          r_we    <= 1'b1;
          r_waddr <= pipe_addr;
          r_wdata <= pipe_data;
        end
        GNT_AUX: begin
          r_we    <= 1'b1;
          r_waddr <= w_head_addr;
          r_wdata <= w_head_data;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  // A stall always pops, so it can never be raised twice in a row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_stall <= !w_empty && !w_pop &&
                 (r_wait == WCW'(STARVE_LIMIT - 1));
      if (w_empty || w_pop) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

`ifdef WBARB_FWD_EN
  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = '0;
    if (r_we && r_waddr == fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = r_wdata;
    end
    for (int k = FIFO_DEPTH - 1; k >= 0; k--) begin
      w_idx = w_wptr - PW'(k + 1);
      if (CW'(k) < w_count &&
          w_ent_addr[w_idx*ADDR_W +: ADDR_W] == fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = w_ent_data[w_idx*DATA_W +: DATA_W];
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_port_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_we;
  logic [AW-1:0] pipe_addr;
  logic [DW-1:0] pipe_data;
  logic          pipe_stall;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_data;
  logic [CW-1:0] aux_pending;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef WBARB_FWD_EN
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_W       (DW),
    .ADDR_W       (AW),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pipe_we     (pipe_we),
    .pipe_addr   (pipe_addr),
    .pipe_data   (pipe_data),
    .pipe_stall  (pipe_stall),
    .aux_valid   (aux_valid),
    .aux_ready   (aux_ready),
    .aux_addr    (aux_addr),
    .aux_data    (aux_data),
    .aux_pending (aux_pending),
`ifdef WBARB_FWD_EN
    .fwd_addr    (fwd_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
`endif
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  logic          m_stall;
  int            m_wait;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pipe_stall", pipe_stall, m_stall);
      chk("aux_ready", aux_ready, m_q.size() != DEPTH);
      chk("aux_pending", aux_pending, m_q.size());
      chk("rf_we", rf_we, m_we);
      if (m_we) begin
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
      end
    end
  end

  // One clock of stimulus; the model advances with the DUT on the edge.
  task automatic cycle(input logic rst, input logic we,
                       input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic av, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad);
    int sz;
    bit pw, pop, push;
    ent_t e;
    reset = rst;
    pipe_we = we;
    pipe_addr = pa;
    pipe_data = pd;
    aux_valid = av;
    aux_addr = aa;
    aux_data = ad;
    sz   = m_q.size();
    pw   = !m_stall && we;
    pop  = !pw && sz > 0;
    push = av && sz < DEPTH;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_stall = 1'b0;
      m_wait = 0;
      m_we = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      m_stall = sz > 0 && !pop && m_wait == LIMIT - 1;
      m_wait = (sz == 0 || pop) ? 0 : m_wait + 1;
      if (pw) begin
        m_we = 1'b1;
        m_addr = pa;
        m_data = pd;
      end else if (pop) begin
        e = m_q.pop_front();
        m_we = 1'b1;
        m_addr = e.a;
        m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (push) m_q.push_back({aa, ad});
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b0;
    pipe_we = 1'b0;
    pipe_addr = '0;
    pipe_data = '0;
    aux_valid = 1'b0;
    aux_addr = '0;
    aux_data = '0;
`ifdef WBARB_FWD_EN
    fwd_addr = '0;
`endif
    m_stall = 1'b0;
    m_wait = 0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;

    cycle(1'b0, 1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd3, 16'h1111);
    cycle(1'b0, 1'b1, 3'd5, 16'hFFFF, 1'b1, 3'd3, 16'h1111);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_pending", aux_pending, 0);
    chk_en = 1'b1;

    cycle(1'b1, 1'b1, 3'd5, 16'hAAAA, 1'b0, '0, '0);
    chk("pipe_we", rf_we, 1);
    chk("pipe_addr", rf_waddr, 5);
    chk("pipe_data", rf_wdata, 16'hAAAA);

    cycle(1'b1, 1'b0, '0, '0, 1'b1, 3'd2, 16'h1234);
    chk("aux_pend1", aux_pending, 1);
    idle();
    chk("aux_we", rf_we, 1);
    chk("aux_addr", rf_waddr, 2);
    chk("aux_data", rf_wdata, 16'h1234);
    chk("aux_pend0", aux_pending, 0);

    cycle(1'b1, 1'b1, 3'd1, 16'h0100, 1'b1, 3'd4, 16'hA0A0);
    cycle(1'b1, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd6, 16'hB0B0);
    chk("fill_ready", aux_ready, 0);
    chk("fill_pend", aux_pending, 2);
    cycle(1'b1, 1'b1, 3'd1, 16'h0102, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 3'd1, 16'h0103, 1'b0, '0, '0);
    chk("fill_nostall", pipe_stall, 0);
    cycle(1'b1, 1'b1, 3'd1, 16'h0104, 1'b0, '0, '0);
    chk("fill_stall", pipe_stall, 1);
    cycle(1'b1, 1'b1, 3'd1, 16'h0105, 1'b0, '0, '0);
    chk("stall_addr", rf_waddr, 4);
    chk("stall_data", rf_wdata, 16'hA0A0);
    chk("stall_drop", pipe_stall, 0);
    cycle(1'b1, 1'b1, 3'd1, 16'h0105, 1'b0, '0, '0);
    chk("resume_data", rf_wdata, 16'h0105);
    idle();

    cycle(1'b1, 1'b1, 3'd6, 16'h5555, 1'b1, 3'd7, 16'h7777);
    chk("sim_addr", rf_waddr, 6);
    chk("sim_pend", aux_pending, 1);
    idle();
    chk("sim_aux_addr", rf_waddr, 7);
    chk("sim_aux_data", rf_wdata, 16'h7777);

`ifdef WBARB_FWD_EN
    cycle(1'b1, 1'b1, 3'd5, 16'h0000, 1'b1, 3'd3, 16'hBEEF);
    fwd_addr = 3'd3;
    #1;
    chk("fwd_hit", fwd_hit, 1);
    chk("fwd_data", fwd_data, 16'hBEEF);
    fwd_addr = 3'd4;
    #1;
    chk("fwd_miss", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    idle();
`endif

    for (int i = 0; i < 800; i++) begin
      int p;
      p = (i < 400) ? 50 : 92;
      cycle($urandom_range(0, 99) != 0,
            $urandom_range(0, 99) < p, AW'($urandom), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
